// File: rtl/dec_gpr_wb_queue_if.sv
// ---- dec_gpr_wb_queue_if: producer/writeback/bypass bundle for the late-writeback queue (rev 1.0) ----
`default_nettype none

interface dec_gpr_wb_queue_if;
  logic        div_wb_valid;
  logic [4:0]  div_wb_addr;
  logic [31:0] div_wb_data;
  logic        div_wb_ready;
  logic        lsu_wb_valid;
  logic [4:0]  lsu_wb_addr;
  logic [31:0] lsu_wb_data;
  logic        lsu_wb_ready;
  logic        port_block;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wd;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic        byp_hit0;
  logic        byp_hit1;
  logic [31:0] byp_data0;
  logic [31:0] byp_data1;
  logic [31:1] pend;
  logic        q_empty;

  modport master (
    output div_wb_valid, div_wb_addr, div_wb_data,
    output lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
    output port_block, rd_addr0, rd_addr1,
    input  div_wb_ready, lsu_wb_ready,
    input  wb_wen, wb_waddr, wb_wd,
    input  byp_hit0, byp_hit1, byp_data0, byp_data1,
    input  pend, q_empty
  );

  modport slave (
    input  div_wb_valid, div_wb_addr, div_wb_data,
    input  lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
    input  port_block, rd_addr0, rd_addr1,
    output div_wb_ready, lsu_wb_ready,
    output wb_wen, wb_waddr, wb_wd,
    output byp_hit0, byp_hit1, byp_data0, byp_data1,
    output pend, q_empty
  );
endinterface

`default_nettype wire

// File: rtl/dec_gpr_wb_queue.sv
// ---- dec_gpr_wb_queue: in-order late-writeback queue feeding GPR write port 2 (rev 1.0) ----
`default_nettype none

module dec_gpr_wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_l,
  dec_gpr_wb_queue_if.slave    wb_if
);

  localparam logic [PTR_W:0] C_DEPTH = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] C_TWO   = {{(PTR_W-1){1'b0}}, 2'b10};

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [4:0]        addr_q  [DEPTH];
  logic [4:0]        addr_d  [DEPTH];
  logic [31:0]       data_q  [DEPTH];
  logic [31:0]       data_d  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q,  count_d;

  logic [PTR_W:0]    free;
  logic              empty;
  logic              div_rdy;
  logic              lsu_rdy;
  logic              div_push;
  logic              lsu_push;
  logic              pop;
  logic [PTR_W-1:0]  lsu_slot;

  // Readiness looks only at registered occupancy; a same-cycle drain never frees a slot early.
  always_comb begin
    free     = C_DEPTH - count_q;
    empty    = (count_q == '0);
    div_rdy  = (free != '0);
    lsu_rdy  = wb_if.div_wb_valid ? (free >= C_TWO) : (free != '0);
    div_push = wb_if.div_wb_valid & div_rdy & (wb_if.div_wb_addr != 5'd0);
    lsu_push = wb_if.lsu_wb_valid & lsu_rdy & (wb_if.lsu_wb_addr != 5'd0);
    pop      = ~empty & ~wb_if.port_block;
    lsu_slot = wr_ptr_q + {{(PTR_W-1){1'b0}}, div_push};
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      addr_d[i]  = addr_q[i];
      data_d[i]  = data_q[i];
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (div_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]  = wb_if.div_wb_addr;
      data_d[wr_ptr_q]  = wb_if.div_wb_data;
    end
    if (lsu_push) begin
      valid_d[lsu_slot] = 1'b1;
      addr_d[lsu_slot]  = wb_if.lsu_wb_addr;
      data_d[lsu_slot]  = wb_if.lsu_wb_data;
    end
    wr_ptr_d = lsu_slot + {{(PTR_W-1){1'b0}}, lsu_push};
    rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
    count_d  = count_q + {{PTR_W{1'b0}}, div_push} + {{PTR_W{1'b0}}, lsu_push}
             - {{PTR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= 5'd0;
        data_q[i]  <= 32'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        addr_q[i]  <= addr_d[i];
        data_q[i]  <= data_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  logic [PTR_W-1:0] idx;
  logic [31:1]      pend_vec;
  logic             hit0, hit1;
  logic [31:0]      bdata0, bdata1;

  // Walk oldest to youngest so the last match wins and bypass returns the youngest value.
  always_comb begin
    idx      = rd_ptr_q;
    hit0     = 1'b0;
    hit1     = 1'b0;
    bdata0   = 32'd0;
    bdata1   = 32'd0;
    pend_vec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + k[PTR_W-1:0];
      if (valid_q[idx] && (wb_if.rd_addr0 != 5'd0) && (addr_q[idx] == wb_if.rd_addr0)) begin
        hit0   = 1'b1;
        bdata0 = data_q[idx];
      end
      if (valid_q[idx] && (wb_if.rd_addr1 != 5'd0) && (addr_q[idx] == wb_if.rd_addr1)) begin
        hit1   = 1'b1;
        bdata1 = data_q[idx];
      end
    end
    for (int r = 1; r < 32; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (addr_q[i] == r[4:0])) begin
          pend_vec[r] = 1'b1;
        end
      end
    end
  end

  assign wb_if.div_wb_ready = div_rdy;
  assign wb_if.lsu_wb_ready = lsu_rdy;
  assign wb_if.wb_wen       = pop;
  assign wb_if.wb_waddr     = addr_q[rd_ptr_q];
  assign wb_if.wb_wd        = data_q[rd_ptr_q];
  assign wb_if.byp_hit0     = hit0;
  assign wb_if.byp_hit1     = hit1;
  assign wb_if.byp_data0    = bdata0;
  assign wb_if.byp_data1    = bdata1;
  assign wb_if.pend         = pend_vec;
  assign wb_if.q_empty      = empty;

endmodule

`default_nettype wire
